// File: rtl/bp_common_pkg.sv
// Shared ME-interface types for the memory-command arbiter.
package bp_common_pkg;

    localparam int unsigned bp_paddr_width_gp = 22;

    typedef enum logic [0:0] {
        e_idle  = 1'b0,
        e_burst = 1'b1
    } bp_me_mem_arb_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO; full is derived from the registered count,
// so a same-cycle pop never frees a slot for a same-cycle push.
module bsg_fifo_1r1w_small #(
    parameter int unsigned width_p = 1,
    parameter int unsigned els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int unsigned ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem_q [els_p];
    logic [ptr_w-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w-1:0]   cnt_q, cnt_d;
    logic               push, pop;

    assign ready_o = (cnt_q != cnt_w'(els_p));
    assign v_o     = (cnt_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    // Pointer wrap and occupancy update
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) wptr_d = (wptr_q == ptr_w'(els_p - 1)) ? '0 : wptr_q + ptr_w'(1);
        if (pop)  rptr_d = (rptr_q == ptr_w'(els_p - 1)) ? '0 : rptr_q + ptr_w'(1);
        if (push && !pop)      cnt_d = cnt_q + cnt_w'(1);
        else if (pop && !push) cnt_d = cnt_q - cnt_w'(1);
    end

    // Control registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy alone defines validity
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Round-robin arbiter sharing one ME command channel among miss requesters;
// grant is held for a whole burst, responses are routed back by issue order.
module bp_me_mem_cmd_arbiter
    import bp_common_pkg::*;
#(
    parameter int unsigned num_req_p         = 2,
    parameter int unsigned paddr_width_p     = bp_paddr_width_gp,
    parameter int unsigned data_width_p      = 64,
    parameter int unsigned max_outstanding_p = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p-1:0]              req_we_i,
    input  logic [num_req_p*paddr_width_p-1:0] req_addr_i,
    input  logic [num_req_p*data_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]              req_last_i,
    output logic [num_req_p-1:0]              req_ready_o,
    output logic                              mem_v_o,
    output logic                              mem_we_o,
    output logic [paddr_width_p-1:0]          mem_addr_o,
    output logic [data_width_p-1:0]           mem_data_o,
    output logic                              mem_last_o,
    input  logic                              mem_ready_i,
    input  logic                              mem_resp_v_i,
    input  logic [data_width_p-1:0]           mem_resp_data_i,
    output logic                              mem_resp_ready_o,
    output logic [num_req_p-1:0]              resp_v_o,
    output logic [data_width_p-1:0]           resp_data_o,
    input  logic [num_req_p-1:0]              resp_ready_i
);

    localparam int unsigned id_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    bp_me_mem_arb_state_e state_q, state_d;
    logic [id_w-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d;
    logic [id_w-1:0] rr_id, cand, sel_id, fifo_head;
    logic            found, sel_v, accept, push, pop, fifo_ready, fifo_v;

    // First valid requester searching upward from the round-robin pointer
    always_comb begin
        found = 1'b0;
        rr_id = rr_ptr_q;
        cand  = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            cand = id_w'((32'(rr_ptr_q) + i) % num_req_p);
            if (!found && req_v_i[cand]) begin
                found = 1'b1;
                rr_id = cand;
            end
        end
    end

    // Grant selection: burst owner is locked in, idle grants need a free ID slot
    always_comb begin
        sel_id = rr_id;
        sel_v  = 1'b0;
        if (state_q == e_burst) begin
            sel_id = owner_q;
            sel_v  = req_v_i[owner_q];
        end else begin
            sel_v  = found & fifo_ready;
        end
    end

    // Command mux; outputs drop while reset is held so an abandoned burst stops at once
    always_comb begin
        mem_v_o     = reset_n_i & sel_v;
        req_ready_o = '0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        mem_last_o  = 1'b0;
        if (mem_v_o) begin
            req_ready_o[sel_id] = mem_ready_i;
            mem_we_o   = req_we_i[sel_id];
            mem_addr_o = req_addr_i[32'(sel_id)*paddr_width_p +: paddr_width_p];
            mem_data_o = req_data_i[32'(sel_id)*data_width_p +: data_width_p];
            mem_last_o = req_last_i[sel_id];
        end
    end

    assign accept = mem_v_o & mem_ready_i;

    // Next-state: last beat returns to idle and advances the pointer past the winner
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        push     = 1'b0;
        if (accept) begin
            push = (state_q == e_idle);
            if (req_last_i[sel_id]) begin
                state_d  = e_idle;
                rr_ptr_d = (sel_id == id_w'(num_req_p - 1)) ? '0 : sel_id + id_w'(1);
            end else begin
                state_d  = e_burst;
                owner_d  = sel_id;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= e_idle;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    // Response routing to the requester at the head of the issue-order FIFO
    always_comb begin
        resp_v_o = '0;
        if (fifo_v && mem_resp_v_i) resp_v_o[fifo_head] = 1'b1;
        mem_resp_ready_o = fifo_v & resp_ready_i[fifo_head];
    end

    assign pop         = mem_resp_v_i & mem_resp_ready_o;
    assign resp_data_o = mem_resp_data_i;

    bsg_fifo_1r1w_small #(
        .width_p (id_w),
        .els_p   (max_outstanding_p)
    ) id_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (push),
        .data_i    (sel_id),
        .ready_o   (fifo_ready),
        .v_o       (fifo_v),
        .data_o    (fifo_head),
        .yumi_i    (pop)
    );

`ifndef SYNTHESIS
    // A response with nothing outstanding is a protocol violation
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(mem_resp_v_i && !fifo_v))
                else $error("memory response arrived with no outstanding transaction");
        end
    end
`endif

endmodule
